timer_cc: RTL

TIMER_CC -- requirements
Module: timer_cc

---
 rtl/timer_cc_if.sv | 44 ++++
 rtl/timer_cc.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/timer_cc_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_cc_if
//  Description : Control/status bundle of the capture/compare timer. The
//                master side drives count, capture and alarm controls; the
//                slave side (the timer) returns captures, alarms and count.
//  Revision    : 1.0 - initial release
// ============================================================================
interface timer_cc_if #(
    parameter int TIMER_BITWIDTH    = 32,
    parameter int NB_CHANNELS       = 4,
    parameter int PRESCALE_BITWIDTH = 8
);
    logic                                  start_in;
    logic [PRESCALE_BITWIDTH-1:0]          prescale_in;
    logic [NB_CHANNELS-1:0]                capture_in;
    logic [NB_CHANNELS-1:0]                capture_ack_in;
    logic [NB_CHANNELS*TIMER_BITWIDTH-1:0] captured_out;
    logic [NB_CHANNELS-1:0]                capture_valid_out;
    logic [NB_CHANNELS-1:0]                capture_ovf_out;
    logic [NB_CHANNELS-1:0]                alarm_en_in;
    logic [NB_CHANNELS*TIMER_BITWIDTH-1:0] alarm_in;
    logic [NB_CHANNELS-1:0]                alarm_periodic_in;
    logic [NB_CHANNELS-1:0]                alarm_out;
    logic [TIMER_BITWIDTH-1:0]             counter_out;
    logic                                  wrap_out;

    // Controller side
    modport master (
        output start_in, prescale_in, capture_in, capture_ack_in,
        output alarm_en_in, alarm_in, alarm_periodic_in,
        input  captured_out, capture_valid_out, capture_ovf_out,
        input  alarm_out, counter_out, wrap_out
    );

    // Timer side
    modport slave (
        input  start_in, prescale_in, capture_in, capture_ack_in,
        input  alarm_en_in, alarm_in, alarm_periodic_in,
        output captured_out, capture_valid_out, capture_ovf_out,
        output alarm_out, counter_out, wrap_out
    );
endinterface
`default_nettype wire

// File: rtl/timer_cc.sv
`default_nettype none
// ============================================================================
//  Module      : timer_cc
//  Description : Prescaled free-running counter with NB_CHANNELS independent
//                capture channels (edge-triggered, valid/overflow/ack) and
//                compare channels (one-shot absolute or periodic alarms).
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_cc #(
    parameter int TIMER_BITWIDTH    = 32,
    parameter int NB_CHANNELS       = 4,
    parameter int PRESCALE_BITWIDTH = 8
) (
    input  wire logic   clk_in,
    input  wire logic   rst_an_in,
    input  wire logic   rst_in,
    timer_cc_if.slave   tmr_bus
);

    localparam logic [TIMER_BITWIDTH-1:0]    c_cnt_one   = TIMER_BITWIDTH'(1);
    localparam logic [TIMER_BITWIDTH-1:0]    c_cnt_max   = '1;
    localparam logic [TIMER_BITWIDTH-1:0]    c_cnt_zero  = '0;
    localparam logic [PRESCALE_BITWIDTH-1:0] c_presc_one = PRESCALE_BITWIDTH'(1);

    // ------------------------------------------------------------------
    // Time base
    // ------------------------------------------------------------------
    logic [PRESCALE_BITWIDTH-1:0] r_presc;
    logic [TIMER_BITWIDTH-1:0]    r_count;
    logic                         r_wrap;
    // Low for the first cycle after any reset so that inputs already high
    // when reset releases are taken as history, not as fresh edges.
    logic                         r_primed;

    logic                         w_tick;
    logic [TIMER_BITWIDTH-1:0]    w_count_inc;

    assign w_tick      = tmr_bus.start_in && (r_presc == tmr_bus.prescale_in);
    assign w_count_inc = r_count + c_cnt_one;

    // Prescaler, counter and wrap pulse; start_in low freezes both counters
    always_ff @(posedge clk_in or negedge rst_an_in) begin
        if (!rst_an_in) begin
            r_presc  <= '0;
            r_count  <= '0;
            r_wrap   <= 1'b0;
            r_primed <= 1'b0;
        end else if (rst_in) begin
            r_presc  <= '0;
            r_count  <= '0;
            r_wrap   <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            r_wrap   <= 1'b0;
            if (tmr_bus.start_in) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_count <= w_count_inc;
                    r_wrap  <= (r_count == c_cnt_max);
                end else begin
                    r_presc <= r_presc + c_presc_one;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture channels
    // ------------------------------------------------------------------
    logic [NB_CHANNELS-1:0]                r_cap_prev;
    logic [NB_CHANNELS-1:0]                r_cap_valid;
    logic [NB_CHANNELS-1:0]                r_cap_ovf;
    logic [NB_CHANNELS*TIMER_BITWIDTH-1:0] r_captured;
    logic [NB_CHANNELS-1:0]                w_cap_edge;

    assign w_cap_edge = tmr_bus.capture_in & ~r_cap_prev & {NB_CHANNELS{r_primed}};

    // Per-channel capture: an ack in the edge cycle frees the slot for the new value
    always_ff @(posedge clk_in or negedge rst_an_in) begin
        if (!rst_an_in) begin
            r_cap_prev  <= '0;
            r_cap_valid <= '0;
            r_cap_ovf   <= '0;
            r_captured  <= '0;
        end else if (rst_in) begin
            r_cap_prev  <= '0;
            r_cap_valid <= '0;
            r_cap_ovf   <= '0;
            r_captured  <= '0;
        end else begin
            r_cap_prev <= tmr_bus.capture_in;
            for (int i = 0; i < NB_CHANNELS; i++) begin
                if (w_cap_edge[i] && (!r_cap_valid[i] || tmr_bus.capture_ack_in[i])) begin
                    r_captured[i*TIMER_BITWIDTH +: TIMER_BITWIDTH] <= r_count;
                    r_cap_valid[i] <= 1'b1;
                    r_cap_ovf[i]   <= 1'b0;
                end else if (w_cap_edge[i]) begin
                    r_cap_ovf[i]   <= 1'b1;
                end else if (tmr_bus.capture_ack_in[i]) begin
                    r_cap_valid[i] <= 1'b0;
                    r_cap_ovf[i]   <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare / alarm channels
    // ------------------------------------------------------------------
    logic [NB_CHANNELS-1:0]                r_en_prev;
    logic [NB_CHANNELS-1:0]                r_armed;
    logic [NB_CHANNELS-1:0]                r_periodic;
    logic [NB_CHANNELS-1:0]                r_alarm;
    logic [NB_CHANNELS*TIMER_BITWIDTH-1:0] r_compare;
    logic [NB_CHANNELS*TIMER_BITWIDTH-1:0] r_period;
    logic [NB_CHANNELS-1:0]                w_en_rise;

    assign w_en_rise = tmr_bus.alarm_en_in & ~r_en_prev & {NB_CHANNELS{r_primed}};

    // Per-channel arm/fire; mode and period are latched at arm time so live
    // input changes have no effect until the next rising edge of alarm_en_in
    always_ff @(posedge clk_in or negedge rst_an_in) begin
        if (!rst_an_in) begin
            r_en_prev  <= '0;
            r_armed    <= '0;
            r_periodic <= '0;
            r_alarm    <= '0;
            r_compare  <= '0;
            r_period   <= '0;
        end else if (rst_in) begin
            r_en_prev  <= '0;
            r_armed    <= '0;
            r_periodic <= '0;
            r_alarm    <= '0;
            r_compare  <= '0;
            r_period   <= '0;
        end else begin
            r_en_prev <= tmr_bus.alarm_en_in;
            for (int i = 0; i < NB_CHANNELS; i++) begin
                r_alarm[i] <= 1'b0;
                if (!tmr_bus.alarm_en_in[i]) begin
                    r_armed[i] <= 1'b0;
                end else if (w_en_rise[i]) begin
                    r_periodic[i] <= tmr_bus.alarm_periodic_in[i];
                    r_period[i*TIMER_BITWIDTH +: TIMER_BITWIDTH] <=
                        tmr_bus.alarm_in[i*TIMER_BITWIDTH +: TIMER_BITWIDTH];
                    if (tmr_bus.alarm_periodic_in[i]) begin
                        r_compare[i*TIMER_BITWIDTH +: TIMER_BITWIDTH] <=
                            r_count + tmr_bus.alarm_in[i*TIMER_BITWIDTH +: TIMER_BITWIDTH];
                        // A zero period would fire on every tick forever; refuse it
                        r_armed[i] <= (tmr_bus.alarm_in[i*TIMER_BITWIDTH +: TIMER_BITWIDTH]
                                       != c_cnt_zero);
                    end else begin
                        r_compare[i*TIMER_BITWIDTH +: TIMER_BITWIDTH] <=
                            tmr_bus.alarm_in[i*TIMER_BITWIDTH +: TIMER_BITWIDTH];
                        r_armed[i] <= 1'b1;
                    end
                end else if (r_armed[i] && w_tick &&
                             (w_count_inc == r_compare[i*TIMER_BITWIDTH +: TIMER_BITWIDTH])) begin
                    // Registered so the pulse lines up with counter_out == compare
                    r_alarm[i] <= 1'b1;
                    if (r_periodic[i]) begin
                        r_compare[i*TIMER_BITWIDTH +: TIMER_BITWIDTH] <=
                            r_compare[i*TIMER_BITWIDTH +: TIMER_BITWIDTH] +
                            r_period[i*TIMER_BITWIDTH +: TIMER_BITWIDTH];
                    end else begin
                        r_armed[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign tmr_bus.counter_out       = r_count;
    assign tmr_bus.wrap_out          = r_wrap;
    assign tmr_bus.captured_out      = r_captured;
    assign tmr_bus.capture_valid_out = r_cap_valid;
    assign tmr_bus.capture_ovf_out   = r_cap_ovf;
    assign tmr_bus.alarm_out         = r_alarm;

endmodule
`default_nettype wire
